// File: rtl/comp_cmd_master.sv
`timescale 1ns/1ps
// Command master: queues RD/WR/ADD/SUB requests and issues each as a one-cycle storage command; CMD_MASTER_READBACK_EN adds a result readback.
// Latency from accept a: resp after a+2 (WR/ADD/SUB), a+3 (RD), a+4 (readback); resp_ready low stalls in RESP and the FIFO fills until req_ready drops.
module comp_cmd_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addA,
  input  logic [ADDR_W-1:0] req_addB,
  input  logic [ADDR_W-1:0] req_addC,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [OP_W-1:0]   resp_op,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [OP_W-1:0]   mem_op,
  output logic [ADDR_W-1:0] mem_addA,
  output logic [ADDR_W-1:0] mem_addB,
  output logic [ADDR_W-1:0] mem_addC,
  output logic [DATA_W-1:0] mem_dq_out,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_in,
  output logic              busy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int REQ_W = OP_W + 3*ADDR_W + DATA_W;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_RD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_WR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4);

  typedef enum logic [2:0] {IDLE, ISSUE, RB_ISSUE, RD_WAIT, RESP} state_t;

  logic [REQ_W-1:0] fifo_mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;

  logic [OP_W-1:0]   h_op;
  logic [ADDR_W-1:0] h_addA, h_addB, h_addC;
  logic [DATA_W-1:0] h_data;

  state_t            state, state_nxt;
  logic [OP_W-1:0]   cur_op, cur_op_nxt;
  logic [ADDR_W-1:0] cur_addc, cur_addc_nxt;
  logic [OP_W-1:0]   mem_op_nxt;
  logic [ADDR_W-1:0] mem_adda_nxt, mem_addb_nxt, mem_addc_nxt;
  logic [DATA_W-1:0] mem_dq_out_nxt;
  logic              mem_dq_oe_nxt;
  logic              resp_valid_nxt;
  logic [OP_W-1:0]   resp_op_nxt;
  logic [DATA_W-1:0] resp_data_nxt;
  logic              resp_err_nxt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;

  assign {h_op, h_addA, h_addB, h_addC, h_data} = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {req_op, req_addA, req_addB, req_addC, req_data};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cur_op     <= '0;
      cur_addc   <= '0;
      mem_op     <= OP_NOP;
      mem_addA   <= '0;
      mem_addB   <= '0;
      mem_addC   <= '0;
      mem_dq_out <= '0;
      mem_dq_oe  <= 1'b0;
      resp_valid <= 1'b0;
      resp_op    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_op     <= cur_op_nxt;
      cur_addc   <= cur_addc_nxt;
      mem_op     <= mem_op_nxt;
      mem_addA   <= mem_adda_nxt;
      mem_addB   <= mem_addb_nxt;
      mem_addC   <= mem_addc_nxt;
      mem_dq_out <= mem_dq_out_nxt;
      mem_dq_oe  <= mem_dq_oe_nxt;
      resp_valid <= resp_valid_nxt;
      resp_op    <= resp_op_nxt;
      resp_data  <= resp_data_nxt;
      resp_err   <= resp_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_op_nxt     = cur_op;
    cur_addc_nxt   = cur_addc;
    mem_op_nxt     = mem_op;
    mem_adda_nxt   = mem_addA;
    mem_addb_nxt   = mem_addB;
    mem_addc_nxt   = mem_addC;
    mem_dq_out_nxt = mem_dq_out;
    mem_dq_oe_nxt  = mem_dq_oe;
    resp_valid_nxt = resp_valid;
    resp_op_nxt    = resp_op;
    resp_data_nxt  = resp_data;
    resp_err_nxt   = resp_err;
    case (state)
      IDLE: begin
        if (!empty) begin
          cur_op_nxt    = h_op;
          cur_addc_nxt  = h_addC;
          resp_op_nxt   = h_op;
          resp_data_nxt = '0;
          resp_err_nxt  = 1'b0;
          if (h_op > OP_SUB) begin
            resp_err_nxt   = 1'b1;
            resp_valid_nxt = 1'b1;
            state_nxt      = RESP;
          end else if (h_op == OP_NOP) begin
            resp_valid_nxt = 1'b1;
            state_nxt      = RESP;
          end else begin
            mem_op_nxt   = h_op;
            mem_adda_nxt = h_addA;
            mem_addb_nxt = h_addB;
            mem_addc_nxt = h_addC;
            if (h_op == OP_WR) begin
              mem_dq_out_nxt = h_data;
              mem_dq_oe_nxt  = 1'b1;
            end
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_op_nxt    = OP_NOP;
        mem_dq_oe_nxt = 1'b0;
        if (cur_op == OP_RD) begin
          state_nxt = RD_WAIT;
        end else begin
`ifdef CMD_MASTER_READBACK_EN
          // Read the destination back so the response carries the stored result.
          mem_op_nxt   = OP_RD;
          mem_adda_nxt = cur_addc;
          state_nxt    = RB_ISSUE;
`else
          resp_data_nxt  = '0;
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
`endif
        end
      end
      RB_ISSUE: begin
        mem_op_nxt = OP_NOP;
        state_nxt  = RD_WAIT;
      end
      RD_WAIT: begin
        resp_data_nxt  = mem_dq_in;
        resp_valid_nxt = 1'b1;
        state_nxt      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
